// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of decode_stage.
// The master modport is the decode stage itself; slave is its environment.
interface decode_stage_if #(
  parameter int INSTR_W = 32,
  parameter int REG_AW  = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic               out_valid;
  logic               out_ready;
  logic               out_read_enable;
  logic [REG_AW-1:0]  out_read_addr1;
  logic [REG_AW-1:0]  out_read_addr2;
  logic [REG_AW-1:0]  out_write_addr;
  logic [INSTR_W-1:0] out_imm;
  logic [2:0]         out_alu_op;
  logic               out_reg_wr;
  logic               out_mem_rd;
  logic               out_mem_wr;
  logic               out_alu_src;

  modport master (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_read_enable, out_read_addr1, out_read_addr2,
           out_write_addr, out_imm, out_alu_op, out_reg_wr, out_mem_rd,
           out_mem_wr, out_alu_src
  );

  modport slave (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_read_enable, out_read_addr1, out_read_addr2,
           out_write_addr, out_imm, out_alu_op, out_reg_wr, out_mem_rd,
           out_mem_wr, out_alu_src
  );
endinterface

// File: rtl/decode_stage.sv
// Decode stage with load-use interlock and flush; DECODE_ILLEGAL_TRAP_EN drops illegal opcodes and raises sticky illegal_op.
// Latency 1 cycle; the output slot holds stable while out_valid && !out_ready, and fetch stalls behind it.
module decode_stage #(
  parameter int INSTR_W          = 32,
  parameter int OPC_W            = 6,
  parameter int REG_AW           = 5,
  parameter int IMM_W            = 16,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  decode_stage_if.master    bus,
  output logic              illegal_op
);

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_RR   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ALUI = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(4);

  typedef enum logic {RUN, STALL} state_t;

  state_t             state_q;
  logic [3:0]         cnt_q;
  logic               last_ld_valid_q;
  logic [REG_AW-1:0]  last_ld_addr_q;

  logic               out_valid_q;
  logic [REG_AW-1:0]  rd1_q, rd2_q, wa_q;
  logic [INSTR_W-1:0] imm_q;
  logic [2:0]         alu_op_q;
  logic               reg_wr_q, mem_rd_q, mem_wr_q, alu_src_q;

  logic [OPC_W-1:0]   opc;
  logic [REG_AW-1:0]  rs, rt, rd;
  logic [INSTR_W-1:0] imm_d;
  logic [REG_AW-1:0]  wa_d;
  logic [2:0]         alu_op_d;
  logic               reg_wr_d, mem_rd_d, mem_wr_d, alu_src_d;
  logic               uses_rt, hazard, advance, in_ready, accept, stall_start, load_slot;

  assign opc   = bus.in_instr[INSTR_W-1 -: OPC_W];
  assign rs    = bus.in_instr[INSTR_W-OPC_W-1 -: REG_AW];
  assign rt    = bus.in_instr[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
  assign rd    = bus.in_instr[INSTR_W-OPC_W-2*REG_AW-1 -: REG_AW];
  assign imm_d = {{(INSTR_W-IMM_W){bus.in_instr[IMM_W-1]}}, bus.in_instr[IMM_W-1:0]};

  always_comb begin
    wa_d      = '0;
    alu_op_d  = 3'd0;
    reg_wr_d  = 1'b0;
    mem_rd_d  = 1'b0;
    mem_wr_d  = 1'b0;
    alu_src_d = 1'b0;
    case (opc)
      OP_RR: begin
        reg_wr_d = 1'b1;
        alu_op_d = bus.in_instr[2:0];
        wa_d     = rd;
      end
      OP_ALUI: begin
        reg_wr_d  = 1'b1;
        alu_src_d = 1'b1;
        wa_d      = rt;
      end
      OP_LD: begin
        mem_rd_d  = 1'b1;
        reg_wr_d  = 1'b1;
        alu_src_d = 1'b1;
        wa_d      = rt;
      end
      OP_ST: begin
        mem_wr_d  = 1'b1;
        alu_src_d = 1'b1;
      end
      default: ;
    endcase
  end

  // rt only counts as a source for instructions that actually read it
  assign uses_rt     = (opc == OP_RR) || (opc == OP_ST);
  assign hazard      = last_ld_valid_q &&
                       ((last_ld_addr_q == rs) || (uses_rt && (last_ld_addr_q == rt)));
  assign advance     = !out_valid_q || bus.out_ready;
  assign in_ready    = !rst && (state_q == RUN) && !flush && advance && !hazard;
  assign accept      = bus.in_valid && in_ready;
  assign stall_start = (state_q == RUN) && !flush && bus.in_valid && hazard && advance;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic dec_illegal;
  logic illegal_q;
  assign dec_illegal = (opc > OP_ST);
  assign load_slot   = accept && !dec_illegal;
  assign illegal_op  = illegal_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (flush) begin
      illegal_q <= 1'b0;
    end else if (accept && dec_illegal) begin
      illegal_q <= 1'b1;
    end
  end
`else
  assign load_slot  = accept;
  assign illegal_op = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      cnt_q           <= 4'd0;
      last_ld_valid_q <= 1'b0;
      last_ld_addr_q  <= '0;
      out_valid_q     <= 1'b0;
      rd1_q           <= '0;
      rd2_q           <= '0;
      wa_q            <= '0;
      imm_q           <= '0;
      alu_op_q        <= 3'd0;
      reg_wr_q        <= 1'b0;
      mem_rd_q        <= 1'b0;
      mem_wr_q        <= 1'b0;
      alu_src_q       <= 1'b0;
    end else if (flush) begin
      state_q         <= RUN;
      cnt_q           <= 4'd0;
      last_ld_valid_q <= 1'b0;
      out_valid_q     <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (stall_start) begin
            state_q <= STALL;
            cnt_q   <= 4'(LOAD_USE_BUBBLES);
          end
        end
        STALL: begin
          // Leaving on the last count gives exactly LOAD_USE_BUBBLES stalled cycles
          if (cnt_q <= 4'd1) begin
            cnt_q           <= 4'd0;
            state_q         <= RUN;
            last_ld_valid_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= RUN;
      endcase

      if (accept) begin
        last_ld_valid_q <= (opc == OP_LD) && (rt != '0);
        last_ld_addr_q  <= rt;
      end

      if (load_slot) begin
        out_valid_q <= 1'b1;
        rd1_q       <= rs;
        rd2_q       <= rt;
        wa_q        <= wa_d;
        imm_q       <= imm_d;
        alu_op_q    <= alu_op_d;
        reg_wr_q    <= reg_wr_d;
        mem_rd_q    <= mem_rd_d;
        mem_wr_q    <= mem_wr_d;
        alu_src_q   <= alu_src_d;
      end else if (accept || bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_read_enable = out_valid_q;
  assign bus.out_read_addr1  = rd1_q;
  assign bus.out_read_addr2  = rd2_q;
  assign bus.out_write_addr  = wa_q;
  assign bus.out_imm         = imm_q;
  assign bus.out_alu_op      = alu_op_q;
  assign bus.out_reg_wr      = reg_wr_q;
  assign bus.out_mem_rd      = mem_rd_q;
  assign bus.out_mem_wr      = mem_wr_q;
  assign bus.out_alu_src     = alu_src_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (1 and 3 load-use bubbles) share directed stimulus through a selector.
// A transaction-level model predicts each accepted instruction's decoded fields and the slot occupancy.
module tb_decode_stage;

  typedef struct packed {
    logic [4:0]  r1, r2, wa;
    logic [31:0] imm;
    logic [2:0]  op;
    logic        wr, mrd, mwr, src, ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, sel, d_valid, d_flush, d_ready;
  logic [31:0] d_instr;
  logic        il1, il3;
  int          n_checks = 0;
  int          n_fail   = 0;

  logic        mon_in_ready, mon_out_valid, mon_read_en, mon_illegal;
  logic [4:0]  mon_rd1, mon_rd2, mon_wa;
  logic [31:0] mon_imm;
  logic [2:0]  mon_alu_op;
  logic        mon_reg_wr, mon_mem_rd, mon_mem_wr, mon_alu_src;

  exp_t        sb_q[$];
  exp_t        sb_e;
  logic        m_illegal;

  decode_stage_if #(.INSTR_W(32), .REG_AW(5)) b1 ();
  decode_stage_if #(.INSTR_W(32), .REG_AW(5)) b3 ();

  assign b1.in_valid  = d_valid && !sel;
  assign b3.in_valid  = d_valid && sel;
  assign b1.in_instr  = d_instr;
  assign b3.in_instr  = d_instr;
  assign b1.out_ready = d_ready;
  assign b3.out_ready = d_ready;

  decode_stage #(.LOAD_USE_BUBBLES(1)) u1 (.clk(clk), .rst(rst), .flush(d_flush), .bus(b1), .illegal_op(il1));
  decode_stage #(.LOAD_USE_BUBBLES(3)) u3 (.clk(clk), .rst(rst), .flush(d_flush), .bus(b3), .illegal_op(il3));

  always #5 clk = ~clk;

  always_comb begin
    mon_in_ready  = sel ? b3.in_ready        : b1.in_ready;
    mon_out_valid = sel ? b3.out_valid       : b1.out_valid;
    mon_read_en   = sel ? b3.out_read_enable : b1.out_read_enable;
    mon_rd1       = sel ? b3.out_read_addr1  : b1.out_read_addr1;
    mon_rd2       = sel ? b3.out_read_addr2  : b1.out_read_addr2;
    mon_wa        = sel ? b3.out_write_addr  : b1.out_write_addr;
    mon_imm       = sel ? b3.out_imm         : b1.out_imm;
    mon_alu_op    = sel ? b3.out_alu_op      : b1.out_alu_op;
    mon_reg_wr    = sel ? b3.out_reg_wr      : b1.out_reg_wr;
    mon_mem_rd    = sel ? b3.out_mem_rd      : b1.out_mem_rd;
    mon_mem_wr    = sel ? b3.out_mem_wr      : b1.out_mem_wr;
    mon_alu_src   = sel ? b3.out_alu_src     : b1.out_alu_src;
    mon_illegal   = sel ? il3                : il1;
  end

  function automatic exp_t model_decode(input logic [31:0] ins);
    exp_t        e;
    int unsigned opc;
    e     = '0;
    opc   = ins >> 26;
    e.r1  = 5'((ins >> 21) % 32);
    e.r2  = 5'((ins >> 16) % 32);
    e.imm = (ins % 65536) + ((((ins >> 15) % 2) == 1) ? 32'hFFFF0000 : 32'h0);
    case (opc)
      1: begin e.wr = 1'b1; e.op = 3'(ins % 8); e.wa = 5'((ins >> 11) % 32); end
      2: begin e.wr = 1'b1; e.src = 1'b1; e.wa = e.r2; end
      3: begin e.mrd = 1'b1; e.wr = 1'b1; e.src = 1'b1; e.wa = e.r2; end
      4: begin e.mwr = 1'b1; e.src = 1'b1; end
      default: e.ill = (opc != 0);
    endcase
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Model compare: slot occupancy and contents every cycle, then apply this cycle's handshakes
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      m_illegal = 1'b0;
    end else begin
      chk("sb_out_valid", mon_out_valid, sb_q.size() != 0);
      chk("sb_read_enable", mon_read_en, sb_q.size() != 0);
      chk("sb_illegal_op", mon_illegal, m_illegal);
      if (sb_q.size() != 0) begin
        sb_e = sb_q[0];
        chk("sb_read_addr1", mon_rd1, sb_e.r1);
        chk("sb_read_addr2", mon_rd2, sb_e.r2);
        chk("sb_write_addr", mon_wa, sb_e.wa);
        chk("sb_imm", mon_imm, sb_e.imm);
        chk("sb_alu_op", mon_alu_op, sb_e.op);
        chk("sb_ctrl", {mon_reg_wr, mon_mem_rd, mon_mem_wr, mon_alu_src},
            {sb_e.wr, sb_e.mrd, sb_e.mwr, sb_e.src});
      end
      if (d_flush) chk("sb_flush_blocks_fetch", mon_in_ready, 0);
      else if (sb_q.size() != 0 && !d_ready) chk("sb_backpressure_blocks_fetch", mon_in_ready, 0);

      if (sb_q.size() != 0 && (d_ready || d_flush)) void'(sb_q.pop_front());
      if (d_valid && mon_in_ready) begin
        sb_e = model_decode(d_instr);
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (sb_e.ill) m_illegal = 1'b1;
        else sb_q.push_back(sb_e);
`else
        sb_q.push_back(sb_e);
`endif
      end
      if (d_flush) m_illegal = 1'b0;
    end
  end

  task automatic hazard_seq(input int nb);
    int bub;
    bit ok;
    bub = 0;
    ok  = 1'b0;
    d_valid = 1'b1;
    d_instr = 32'h0C240008;
    neg();
    chk("hz_load_ready", mon_in_ready, 1);
    tick();
    d_instr = 32'h04822800;
    neg();
    chk("hz_load_valid", mon_out_valid, 1);
    chk("hz_load_mem_rd", mon_mem_rd, 1);
    chk("hz_load_imm", mon_imm, 32'h8);
    chk("hz_load_write", mon_wa, 4);
    chk("hz_user_blocked", mon_in_ready, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      neg();
      if (mon_in_ready) begin
        ok = 1'b1;
        break;
      end
      if (!mon_out_valid) bub++;
      tick();
    end
    chk("hz_stall_ends", ok, 1);
    chk("hz_bubbles", bub, nb);
    tick();
    d_valid = 1'b0;
    neg();
    chk("hz_user_valid", mon_out_valid, 1);
    chk("hz_user_read1", mon_rd1, 4);
    chk("hz_user_write", mon_wa, 5);
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    sel     = 1'b0;
    d_valid = 1'b0;
    d_flush = 1'b0;
    d_ready = 1'b0;
    d_instr = 32'h0;
    repeat (2) neg();
    chk("rst_in_ready", mon_in_ready, 0);
    chk("rst_out_valid", mon_out_valid, 0);
    chk("rst_imm", mon_imm, 0);
    chk("rst_write", mon_wa, 0);
    chk("rst_ctrl", {mon_reg_wr, mon_mem_rd, mon_mem_wr, mon_alu_src}, 0);
    chk("rst_illegal", mon_illegal, 0);
    tick();
    rst = 1'b0;

    // Back-to-back ALU-RR then ALU-I
    d_ready = 1'b1;
    d_valid = 1'b1;
    d_instr = 32'h04221800;
    neg();
    chk("rr_in_ready", mon_in_ready, 1);
    tick();
    d_instr = 32'h0826FFFF;
    neg();
    chk("rr_valid", mon_out_valid, 1);
    chk("rr_read1", mon_rd1, 1);
    chk("rr_read2", mon_rd2, 2);
    chk("rr_write", mon_wa, 3);
    chk("rr_reg_wr", mon_reg_wr, 1);
    chk("rr_alu_src", mon_alu_src, 0);
    chk("rr_alu_op", mon_alu_op, 0);
    tick();
    d_valid = 1'b0;
    neg();
    chk("ai_imm", mon_imm, 32'hFFFFFFFF);
    chk("ai_write", mon_wa, 6);
    chk("ai_alu_src", mon_alu_src, 1);
    chk("ai_reg_wr", mon_reg_wr, 1);
    tick();

    hazard_seq(1);

    // Load to r0 never interlocks
    d_valid = 1'b1;
    d_instr = 32'h0C200008;
    neg();
    chk("r0_load_ready", mon_in_ready, 1);
    tick();
    d_instr = 32'h04000800;
    neg();
    chk("r0_no_bubble", mon_in_ready, 1);
    chk("r0_load_write", mon_wa, 0);
    tick();
    d_valid = 1'b0;
    neg();
    chk("r0_user_valid", mon_out_valid, 1);
    chk("r0_user_write", mon_wa, 1);
    tick();

    // Downstream backpressure holds the slot
    d_ready = 1'b0;
    d_valid = 1'b1;
    d_instr = 32'h04221800;
    neg();
    chk("bp_first_ready", mon_in_ready, 1);
    tick();
    d_instr = 32'h0826FFFF;
    for (int i = 0; i < 4; i++) begin
      neg();
      chk("bp_valid", mon_out_valid, 1);
      chk("bp_in_ready", mon_in_ready, 0);
      chk("bp_write", mon_wa, 3);
      tick();
    end
    d_ready = 1'b1;
    neg();
    chk("bp_release_ready", mon_in_ready, 1);
    tick();
    d_valid = 1'b0;
    neg();
    chk("bp_next_write", mon_wa, 6);
    tick();

    // Illegal opcode 0x3F
    d_valid = 1'b1;
    d_instr = 32'hFC000000;
    neg();
    chk("ill_in_ready", mon_in_ready, 1);
    tick();
    d_valid = 1'b0;
    neg();
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("ill_dropped", mon_out_valid, 0);
    chk("ill_flag", mon_illegal, 1);
    tick();
    d_flush = 1'b1;
    neg();
    tick();
    d_flush = 1'b0;
    neg();
    chk("ill_flush_clears", mon_illegal, 0);
`else
    chk("ill_as_nop_valid", mon_out_valid, 1);
    chk("ill_flag_tied", mon_illegal, 0);
    chk("ill_nop_ctrl", {mon_reg_wr, mon_mem_rd, mon_mem_wr, mon_alu_src}, 0);
    chk("ill_nop_write", mon_wa, 0);
`endif
    tick();
    tick();

    sel = 1'b1;
    tick();
    hazard_seq(3);

    // Flush in the middle of a stall
    d_valid = 1'b1;
    d_instr = 32'h0C240008;
    neg();
    tick();
    d_instr = 32'h04822800;
    neg();
    tick();
    neg();
    chk("fl_in_stall_valid", mon_out_valid, 0);
    chk("fl_in_stall_ready", mon_in_ready, 0);
    tick();
    d_flush = 1'b1;
    neg();
    tick();
    d_flush = 1'b0;
    neg();
    chk("fl_out_valid", mon_out_valid, 0);
    chk("fl_in_ready", mon_in_ready, 1);
    tick();
    d_valid = 1'b0;
    neg();
    chk("fl_user_valid", mon_out_valid, 1);
    chk("fl_user_write", mon_wa, 5);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, handshaked instruction-decode pipeline stage for the RISC core, sitting between fetch and execute. It splits each accepted instruction into register-file read addresses, write address, sign-extended immediate and execute/memory control, and registers them into a single output slot. A built-in load-use interlock holds fetch for a programmable number of bubble cycles, and a flush input supports branch redirect.

## Interface
- `INSTR_W`, 32: instruction width.
- `OPC_W`, 6: opcode field width, at `instr[INSTR_W-1 -: OPC_W]`.
- `REG_AW`, 5: register address width. Fields follow the opcode: rs, then rt, then rd. Constraint: `OPC_W + 3*REG_AW <= INSTR_W`.
- `IMM_W`, 16: immediate width, at `instr[IMM_W-1:0]`.
- `LOAD_USE_BUBBLES`, 1: bubble cycles on a load-use hazard (1..15).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: synchronous pipeline flush.
- `in_valid` in 1, `in_ready` out 1, `in_instr` in INSTR_W: fetch side.
- `out_valid` out 1, `out_ready` in 1: execute side.
- `out_read_enable` out 1: equals `out_valid`.
- `out_read_addr1` out REG_AW: rs.
- `out_read_addr2` out REG_AW: rt.
- `out_write_addr` out REG_AW: destination register.
- `out_imm` out INSTR_W: sign-extended immediate.
- `out_alu_op` out 3.
- `out_reg_wr` out 1.
- `out_mem_rd` out 1.
- `out_mem_wr` out 1.
- `out_alu_src` out 1: 1 selects the immediate.
- `illegal_op` out 1: sticky trap flag; see Configuration.

## Operation
- Opcode map:
  - 0 NOP: all controls 0.
  - 1 ALU-RR: reg_wr=1, alu_src=0, alu_op=`instr[2:0]`, write_addr=rd.
  - 2 ALU-I: reg_wr=1, alu_src=1, alu_op=0, write_addr=rt.
  - 3 LOAD: mem_rd=1, reg_wr=1, alu_src=1, alu_op=0, write_addr=rt.
  - 4 STORE: mem_wr=1, alu_src=1, alu_op=0, write_addr=0.
  - Any other opcode: illegal.
- Register r0 as a destination never forms a hazard.
- Accept: `in_valid && in_ready`. `in_ready = (state==RUN) && !flush && (!out_valid || out_ready) && !hazard`.
- `hazard` is set when both of these hold:
  - The last accepted instruction was a LOAD with a nonzero destination.
  - That destination equals the incoming rs, or equals the incoming rt when the incoming instruction is ALU-RR or STORE.
- Tracking register `last_ld_valid`/`last_ld_addr` is updated on every accept; it is cleared when a non-load is accepted or when the stall ends.
- FSM states RUN and STALL:
  - RUN→STALL when `in_valid && hazard` and the slot is advancing. The counter loads `LOAD_USE_BUBBLES`, and the slot empties (bubble, `out_valid=0`).
  - In STALL, the counter decrements once per cycle. At 0, `last_ld_valid` clears and the FSM returns to RUN; the held instruction is accepted in the following cycle.
- Output slot:
  - On accept, load the decoded fields and set `out_valid=1`.
  - If no accept but `out_ready`, clear `out_valid`.
  - Otherwise hold all outputs stable (backpressure).
- Flush has priority over accept and stall. It clears `out_valid`, the counter and `last_ld_valid`, and returns the FSM to RUN, all on the same edge.

## Timing
- Latency: 1 cycle. An instruction accepted at edge N is on the outputs after edge N.
- Throughput: 1 instruction/cycle when there is no hazard and no backpressure.
- Reset values: `out_valid=0`, all control/address/immediate outputs 0, `illegal_op=0`, state RUN, counter 0, `last_ld_valid=0`. `in_ready` is 0 during reset.
- Reset asserted mid-stall aborts the stall immediately and asynchronously.
- Outputs never change while `out_valid && !out_ready` unless `flush` or `rst` is asserted.
- Hazard fetch stall is `LOAD_USE_BUBBLES` cycles beyond any downstream backpressure.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN`:
  - Defined: an illegal opcode is accepted and dropped (slot not loaded), and `illegal_op` is set sticky until `rst` or `flush`.
  - Undefined: an illegal opcode decodes as NOP with `out_valid=1`, and `illegal_op` is tied 0.

## Test plan
- Reset, then `0x04221800` with `out_ready=1` → next cycle `out_valid=1`, read1=1, read2=2, write=3, reg_wr=1, alu_src=0, alu_op=0.
- `0x0826FFFF` → `out_imm=0xFFFFFFFF`, write=6, alu_src=1, reg_wr=1.
- `0x0C240008` then `0x04822800` back-to-back → LOAD out (mem_rd=1, imm=8, write=4). Then `in_ready=0` and `out_valid=0` for 1 cycle, then the ALU-RR with read1=4 and write=5. Repeat with `LOAD_USE_BUBBLES=3` → 3 bubbles.
- Load to r0 (`0x0C200008`) followed by a reader of r0 → no bubble.
- `out_ready=0` for 4 cycles with `out_valid=1` → outputs stable and `in_ready=0`. Assert `flush` during a STALL → `out_valid=0` next cycle and `in_ready=1` in the cycle after.
- Opcode `0x3F` with `DECODE_ILLEGAL_TRAP_EN` → `illegal_op=1`, `out_valid` stays 0. Without the macro → NOP with `out_valid=1`, `illegal_op=0`.
